register_file_param: RTL and testbench
======================================

# register_file_param

Parametrised register file: single clock, one write port, two read ports with registered outputs, and a sequential clear engine that zeroes every entry, one per cycle. It replaces the fixed 2×8-bit register file as the datapath register store. It sits between the decode stage, which supplies read/write addresses, and the ALU/writeback path, which consumes read data and supplies write data.

## Interface
- DATA_W, 8, width of each register in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
- ZERO_R0, 0, when 1, entry 0 is hard-wired to zero
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr0  input  ADDR_W  read port 0 address
- raddr1  input  ADDR_W  read port 1 address
- rdata0  output  DATA_W  registered read data, port 0
- rdata1  output  DATA_W  registered read data, port 1
- clr_req  input  1  request a full clear, sampled when idle
- busy  output  1  high while the clear engine runs
- wr_drop  output  1  one-cycle pulse: the write in the previous cycle was discarded

## Operation
- Reset is synchronous and active-low: any rising clk edge with rst_n=0 applies reset. On reset:
  - all entries, rdata0 and rdata1 go to 0
  - busy=0, wr_drop=0, clear counter=0, FSM=IDLE
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR: clr_req=1 at an edge. Counter loads 0; busy=1 from the next cycle.
  - CLEAR: each edge writes 0 to entry[counter], then increments the counter.
  - CLEAR → IDLE: at the edge that clears entry DEPTH-1. busy drops the following cycle.
  - clr_req is ignored in CLEAR.
- A write is accepted only in IDLE with clr_req=0: mem[waddr] <= wdata at the edge.
- A write is dropped, and wr_drop pulses the next cycle, when we=1 and any of the following holds:
  - FSM is in CLEAR
  - clr_req=1 in the same cycle (clear wins)
  - ZERO_R0=1 and waddr=0
- Reads are always active. At each edge, rdataN <= mem[raddrN], the contents before that edge.
  - The bypass rule in Configuration applies on top of this.
  - With ZERO_R0=1, raddrN=0 always yields 0.
- Clear-engine writes are never bypassed to read ports. Reads during CLEAR return the current array contents: entries already cleared read 0, the rest read their old value.

## Timing
- Read latency: 1 cycle. The address presented before edge t appears on rdataN after edge t.
- Write latency: 1 cycle. Without bypass, a read issued the cycle after the write sees the new value.
- Clear occupies exactly DEPTH cycles in CLEAR; busy is high for DEPTH cycles.
- wr_drop is registered: high for exactly one cycle per dropped write.
- Reset mid-clear: FSM returns to IDLE, all entries go to 0, busy=0 the next cycle.
- Reset has priority over all other inputs.
- Simultaneous same-address write and read on both ports: both ports obey the same bypass rule.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: an accepted write at edge t with waddr==raddrN makes rdataN = wdata after edge t (write-through forwarding).
  - Undefined: rdataN shows the pre-write value at edge t; the new value appears at edge t+1.
  - Dropped writes are never forwarded.
  - ZERO_R0 zeroing overrides forwarding.

## Test plan
- Reset: preload the entries with writes, then hold rst_n=0 for one edge → rdata0=rdata1=0, busy=0, and every entry reads 0 afterwards.
- Basic write/read (DATA_W=8, ADDR_W=2): write 0xA5 to addr 2, then read raddr0=2, raddr1=2 on the next cycle → both ports show 0xA5 one cycle later.
- Same-cycle write/read: write 0x3C to addr 1 while raddr0=1 and the old value is 0x11 → rdata0=0x3C with REGFILE_BYPASS_EN defined, 0x11 without it.
- Clear sequence: fill entries with 0xFF, pulse clr_req, and issue we=1 to addr 3 on the second busy cycle →
  - busy is high for 4 cycles
  - wr_drop pulses once
  - all entries read 0x00 afterwards
- clr_req and we in the same cycle → write dropped, wr_drop=1 the next cycle, clear proceeds.
- ZERO_R0=1: write 0x77 to addr 0 → wr_drop=1, and raddr0=0 reads 0x00. Reset during CLEAR at counter=2 → busy=0 the next cycle and the FSM is back in IDLE.

Source files
------------

// File: rtl/register_file_param.sv
// register_file_param
// Parametrised register file: one write port, two registered read ports and a
// sequential clear engine that zeroes one entry per cycle.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding of an
// accepted write to any read port addressing the same entry in that cycle).
module register_file_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] clrCount;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              zeroWrite;
  logic              writeAccept;
  logic              writeDrop;
  logic              clearLast;
  logic [DATA_W-1:0] nextRd0;
  logic [DATA_W-1:0] nextRd1;

  // A write lands only when idle and no clear is being requested; a write to
  // the hard-wired zero entry is refused. Anything else with we=1 is dropped.
  assign zeroWrite   = (ZERO_R0 != 0) && (waddr == '0);
  assign writeAccept = we && (state == IDLE) && !clr_req && !zeroWrite;
  assign writeDrop   = we && !writeAccept;
  assign clearLast   = (state == CLEAR) && (clrCount == ADDR_W'(DEPTH - 1));
  assign busy        = (state == CLEAR);

  // State register for the clear engine.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: start clearing on a request while idle, stop after the last entry.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (clr_req)   nextState = CLEAR;
      CLEAR:   if (clearLast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Clear pointer: loaded with 0 when a clear starts, advanced once per clear cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clrCount <= '0;
    end else if (state == IDLE) begin
      if (clr_req) clrCount <= '0;
    end else begin
      clrCount <= clrCount + ADDR_W'(1);
    end
  end

  // Storage array: the clear engine owns the array while clearing, otherwise
  // accepted writes update it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clrCount] <= '0;
    end else if (writeAccept) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data selection: pre-edge array contents, optionally forwarded from an
  // accepted write, with the zero entry forced to 0 last so it wins.
  always_comb begin
    nextRd0 = mem[raddr0];
    nextRd1 = mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (writeAccept && (waddr == raddr0)) nextRd0 = wdata;
    if (writeAccept && (waddr == raddr1)) nextRd1 = wdata;
`else
`endif
    if ((ZERO_R0 != 0) && (raddr0 == '0)) nextRd0 = '0;
    if ((ZERO_R0 != 0) && (raddr1 == '0)) nextRd1 = '0;
  end

  // Registered read ports and the one-cycle dropped-write flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata0  <= '0;
      rdata1  <= '0;
      wr_drop <= 1'b0;
    end else begin
      rdata0  <= nextRd0;
      rdata1  <= nextRd1;
      wr_drop <= writeDrop;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param
// Drives two register files side by side (ZERO_R0=0 and ZERO_R0=1) with the
// same inputs and checks them against a behavioural model of the register store.
// Honours REGFILE_BYPASS_EN when the bundle is built with it.
module tb_register_file_param;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic          clr_req;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr0;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata0A, rdata1A, rdata0B, rdata1B;
  logic          busyA, busyB, wrDropA, wrDropB;

  int total = 0;
  int bad   = 0;

  // Reference model state: array contents per instance, expected registered
  // outputs, and the number of clear cycles still to run.
  logic [DW-1:0] mMem [2][DEPTH];
  logic [DW-1:0] eRd0 [2];
  logic [DW-1:0] eRd1 [2];
  logic          eDrop [2];
  int            clearLeft;

  // Free-running clock.
  always #5 clk = ~clk;

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) dutA (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0A), .rdata1(rdata1A),
    .clr_req(clr_req), .busy(busyA), .wr_drop(wrDropA)
  );

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dutB (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0B), .rdata1(rdata1B),
    .clr_req(clr_req), .busy(busyB), .wr_drop(wrDropB)
  );

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic modelStep();
    bit z;
    bit accepted;
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < DEPTH; i++) mMem[n][i] = '0;
        eRd0[n]  = '0;
        eRd1[n]  = '0;
        eDrop[n] = 1'b0;
      end
      clearLeft = 0;
      return;
    end
    for (int n = 0; n < 2; n++) begin
      z        = (n == 1);
      accepted = we && (clearLeft == 0) && !clr_req && !(z && (waddr == 0));
      if (z && (raddr0 == 0))                        eRd0[n] = '0;
      else if (BYPASS && accepted && waddr == raddr0) eRd0[n] = wdata;
      else                                           eRd0[n] = mMem[n][raddr0];
      if (z && (raddr1 == 0))                        eRd1[n] = '0;
      else if (BYPASS && accepted && waddr == raddr1) eRd1[n] = wdata;
      else                                           eRd1[n] = mMem[n][raddr1];
      eDrop[n] = we && !accepted;
      if (clearLeft > 0)  mMem[n][DEPTH - clearLeft] = '0;
      else if (accepted)  mMem[n][waddr] = wdata;
    end
    if (clearLeft > 0)  clearLeft = clearLeft - 1;
    else if (clr_req)   clearLeft = DEPTH;
  endtask

  // Present one cycle of inputs, clock it in, update the model, settle.
  task automatic applyStimulus(input logic rstN, input logic weIn,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                               input logic clr);
    rst_n   = rstN;
    we      = weIn;
    waddr   = wa;
    wdata   = wd;
    raddr0  = ra0;
    raddr1  = ra1;
    clr_req = clr;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Preload, reset for one edge, then every entry must read back 0.
  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 1, AW'(i), DW'(8'h11 * (i + 1)), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    total++; if (rdata0A !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata0: got %h want 00", rdata0A); end
    total++; if (rdata1A !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata1: got %h want 00", rdata1A); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
    total++; if (wrDropA !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_drop: got %b want 0", wrDropA); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, AW'(i), AW'(i), 0);
      total++; if (rdata0A !== 8'h00) begin bad++; $display("[TB] FAIL reset_entry%0d_p0: got %h want 00", i, rdata0A); end
      total++; if (rdata1A !== 8'h00) begin bad++; $display("[TB] FAIL reset_entry%0d_p1: got %h want 00", i, rdata1A); end
    end
  endtask

  // Write then read on the following cycle through both ports.
  task automatic test_basic();
    applyStimulus(1, 1, 2, 8'hA5, 0, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 2, 2, 0);
    total++; if (rdata0A !== 8'hA5) begin bad++; $display("[TB] FAIL basic_p0: got %h want a5", rdata0A); end
    total++; if (rdata1A !== 8'hA5) begin bad++; $display("[TB] FAIL basic_p1: got %h want a5", rdata1A); end
    total++; if (rdata0B !== 8'hA5) begin bad++; $display("[TB] FAIL basic_z_p0: got %h want a5", rdata0B); end
  endtask

  // Same-cycle write and read of one address on both ports.
  task automatic test_same_cycle();
    logic [DW-1:0] want;
    want = BYPASS ? 8'h3C : 8'h11;
    applyStimulus(1, 1, 1, 8'h11, 0, 0, 0);
    applyStimulus(1, 1, 1, 8'h3C, 1, 1, 0);
    total++; if (rdata0A !== want) begin bad++; $display("[TB] FAIL same_cycle_p0: got %h want %h", rdata0A, want); end
    total++; if (rdata1A !== want) begin bad++; $display("[TB] FAIL same_cycle_p1: got %h want %h", rdata1A, want); end
    applyStimulus(1, 0, 0, 8'h00, 1, 1, 0);
    total++; if (rdata0A !== 8'h3C) begin bad++; $display("[TB] FAIL same_cycle_after: got %h want 3c", rdata0A); end
  endtask

  // Full clear with a write attempted on the second busy cycle.
  task automatic test_clear();
    int busyCnt;
    int dropCnt;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, AW'(i), 8'hFF, 0, 0, 0);
    applyStimulus(1, 0, 0, 8'h00, 0, 0, 1);
    busyCnt = int'(busyA);
    dropCnt = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(1, (k == 2), 3, 8'h99, 3, 3, 0);
      busyCnt += int'(busyA);
      dropCnt += int'(wrDropA);
    end
    total++; if (busyCnt != DEPTH) begin bad++; $display("[TB] FAIL clear_busy_cycles: got %0d want %0d", busyCnt, DEPTH); end
    total++; if (dropCnt != 1) begin bad++; $display("[TB] FAIL clear_drop_pulses: got %0d want 1", dropCnt); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL clear_busy_end: got %b want 0", busyA); end
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, AW'(i), AW'(i), 0);
      total++; if (rdata0A !== 8'h00) begin bad++; $display("[TB] FAIL clear_entry%0d: got %h want 00", i, rdata0A); end
    end
  endtask

  // Clear request and write in the same cycle: clear wins.
  task automatic test_clr_we_same();
    applyStimulus(1, 1, 2, 8'h5A, 0, 0, 1);
    total++; if (wrDropA !== 1'b1) begin bad++; $display("[TB] FAIL clrwe_drop: got %b want 1", wrDropA); end
    total++; if (busyA !== 1'b1) begin bad++; $display("[TB] FAIL clrwe_busy: got %b want 1", busyA); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    total++; if (wrDropA !== 1'b0) begin bad++; $display("[TB] FAIL clrwe_drop_pulse: got %b want 0", wrDropA); end
    for (int k = 0; k < DEPTH - 1; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL clrwe_busy_end: got %b want 0", busyA); end
    applyStimulus(1, 0, 0, 0, 2, 2, 0);
    total++; if (rdata0A !== 8'h00) begin bad++; $display("[TB] FAIL clrwe_entry2: got %h want 00", rdata0A); end
  endtask

  // Hard-wired entry 0, then reset in the middle of a clear.
  task automatic test_zero_r0();
    applyStimulus(1, 1, 0, 8'h77, 0, 0, 0);
    total++; if (wrDropB !== 1'b1) begin bad++; $display("[TB] FAIL zr0_drop: got %b want 1", wrDropB); end
    total++; if (wrDropA !== 1'b0) begin bad++; $display("[TB] FAIL zr0_nodrop_ref: got %b want 0", wrDropA); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    total++; if (rdata0B !== 8'h00) begin bad++; $display("[TB] FAIL zr0_read: got %h want 00", rdata0B); end
    total++; if (rdata0A !== 8'h77) begin bad++; $display("[TB] FAIL zr0_read_ref: got %h want 77", rdata0A); end
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    total++; if (busyA !== 1'b1) begin bad++; $display("[TB] FAIL midclr_busy_before: got %b want 1", busyA); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL midclr_busy: got %b want 0", busyA); end
    total++; if (busyB !== 1'b0) begin bad++; $display("[TB] FAIL midclr_busy_z: got %b want 0", busyB); end
    applyStimulus(1, 1, 1, 8'h42, 0, 0, 0);
    total++; if (wrDropA !== 1'b0) begin bad++; $display("[TB] FAIL midclr_idle_write: got %b want 0", wrDropA); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL midclr_still_idle: got %b want 0", busyA); end
    applyStimulus(1, 0, 0, 0, 1, 3, 0);
    total++; if (rdata0A !== 8'h42) begin bad++; $display("[TB] FAIL midclr_readback: got %h want 42", rdata0A); end
    total++; if (rdata1A !== 8'h00) begin bad++; $display("[TB] FAIL midclr_entry3: got %h want 00", rdata1A); end
  endtask

  // Random traffic against the model, every output every cycle.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1),
                    AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                    AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
                    ($urandom_range(0, 15) == 0));
      total++; if (rdata0A !== eRd0[0]) begin bad++; $display("[TB] FAIL rand%0d_rd0: got %h want %h", c, rdata0A, eRd0[0]); end
      total++; if (rdata1A !== eRd1[0]) begin bad++; $display("[TB] FAIL rand%0d_rd1: got %h want %h", c, rdata1A, eRd1[0]); end
      total++; if (rdata0B !== eRd0[1]) begin bad++; $display("[TB] FAIL rand%0d_z_rd0: got %h want %h", c, rdata0B, eRd0[1]); end
      total++; if (rdata1B !== eRd1[1]) begin bad++; $display("[TB] FAIL rand%0d_z_rd1: got %h want %h", c, rdata1B, eRd1[1]); end
      total++; if (wrDropA !== eDrop[0]) begin bad++; $display("[TB] FAIL rand%0d_drop: got %b want %b", c, wrDropA, eDrop[0]); end
      total++; if (wrDropB !== eDrop[1]) begin bad++; $display("[TB] FAIL rand%0d_z_drop: got %b want %b", c, wrDropB, eDrop[1]); end
      total++; if (busyA !== (clearLeft > 0)) begin bad++; $display("[TB] FAIL rand%0d_busy: got %b want %b", c, busyA, (clearLeft > 0)); end
      total++; if (busyB !== (clearLeft > 0)) begin bad++; $display("[TB] FAIL rand%0d_z_busy: got %b want %b", c, busyB, (clearLeft > 0)); end
    end
  endtask

  // Test sequence.
  initial begin
    rst_n   = 1'b0;
    we      = 1'b0;
    clr_req = 1'b0;
    waddr   = '0;
    raddr0  = '0;
    raddr1  = '0;
    wdata   = '0;
    clearLeft = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_same_cycle();
    test_clear();
    test_clr_we_same();
    test_zero_r0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
